// File: rtl/part_wwr_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | part_wwr_ram : parametrised write-while-read RAM with post-reset clear      |
// | Optional same-edge write forwarding into dout: define WWR_BYPASS_EN         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module part_wwr_ram #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_n,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  input  logic [LANES-1:0] we_n,
  input  logic             strobe,
  output logic [WIDTH-1:0] dout,
  output logic             ready,
  output logic [AW-1:0]    addr_q
);

  localparam int LW = WIDTH / LANES;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] C_LAST  = IW'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_addr_ok;
  logic             w_addrq_ok;
  logic [IW-1:0]    w_idx;
  logic [IW-1:0]    w_idxq;
  logic [WIDTH-1:0] w_rd_word;
  logic [WIDTH-1:0] w_rq_word;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_wr_ok;

  // Out-of-range addresses are steered to word 0 and their data masked off
  assign w_addr_ok  = {1'b0, addr}   < C_DEPTH;
  assign w_addrq_ok = {1'b0, addr_q} < C_DEPTH;
  assign w_idx      = w_addr_ok  ? addr[IW-1:0]   : '0;
  assign w_idxq     = w_addrq_ok ? addr_q[IW-1:0] : '0;
  assign w_rd_word  = w_addr_ok  ? r_mem[w_idx]   : '0;
  assign w_rq_word  = w_addrq_ok ? r_mem[w_idxq]  : '0;
  assign w_wr_ok    = (r_state == S_RUN) && !ce_n && w_addr_ok;

`ifdef WWR_BYPASS_EN
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_rd_data[k*LW +: LW] = (!we_n[k] && w_addr_ok) ? din[k*LW +: LW]
                                                            : w_rd_word[k*LW +: LW];
  end
`else
  assign w_rd_data = w_rd_word;
`endif

  // Storage has no reset; the CLEAR state zeroes it one word per cycle
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_ok) begin
      for (int k = 0; k < LANES; k++) begin
        if (!we_n[k]) r_mem[w_idx][k*LW +: LW] <= din[k*LW +: LW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      ready   <= 1'b0;
      dout    <= '0;
      addr_q  <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          dout <= '0;
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_state <= S_RUN;
            ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!ce_n) addr_q <= addr;
          // ce_n high re-reads the latched address, picking up later writes
          if (strobe) dout <= ce_n ? w_rq_word : w_rd_data;
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_part_wwr_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_part_wwr_ram : directed scoreboard bench for part_wwr_ram                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_part_wwr_ram;

  localparam int WIDTH = 8;
  localparam int DEPTH = 20;
  localparam int AW    = 5;
  localparam int LANES = 2;
  localparam int LW    = WIDTH / LANES;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             ce_n;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] din;
  logic [LANES-1:0] we_n;
  logic             strobe;
  logic [WIDTH-1:0] dout;
  logic             ready;
  logic [AW-1:0]    addr_q;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] val;
  } exp_t;
  exp_t exp_q[$];

  logic [WIDTH-1:0] model [DEPTH];

  part_wwr_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .LANES(LANES)) dut (
    .clk(clk), .reset_n(reset_n), .ce_n(ce_n), .addr(addr), .din(din),
    .we_n(we_n), .strobe(strobe), .dout(dout), .ready(ready), .addr_q(addr_q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ce_n = 1'b1; strobe = 1'b0; we_n = '1; din = '0;
  endtask

  task automatic push(input string tag, input logic [WIDTH-1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, 32'(dout), 32'(e.val));
    end
  endtask

  function automatic logic [WIDTH-1:0] mread(input int a);
    return (a < DEPTH) ? model[a] : '0;
  endfunction

  task automatic mwrite(input int a, input logic [WIDTH-1:0] d, input logic [LANES-1:0] w);
    if (a < DEPTH)
      for (int k = 0; k < LANES; k++)
        if (!w[k]) model[a][k*LW +: LW] = d[k*LW +: LW];
  endtask

  task automatic wr(input int a, input logic [WIDTH-1:0] d, input logic [LANES-1:0] w);
    ce_n = 1'b0; strobe = 1'b0; we_n = w; addr = AW'(a); din = d;
    mwrite(a, d, w);
    tick();
    idle();
  endtask

  task automatic rd(input string tag, input int a);
    ce_n = 1'b0; strobe = 1'b1; we_n = '1; addr = AW'(a);
    push(tag, mread(a));
    tick();
    pop_chk();
    chk("addr_q_after_read", 32'(addr_q), 32'(a));
    idle();
  endtask

  // Inputs are driven with garbage throughout the clear to prove they are ignored
  task automatic clear_seq();
    for (int c = 0; c <= DEPTH; c++) begin
      chk("ready_during_clear", 32'(ready), (c >= DEPTH) ? 32'd1 : 32'd0);
      if (c < DEPTH) begin
        chk("dout_during_clear", 32'(dout), 32'd0);
        ce_n = 1'b0; strobe = 1'b1; we_n = '0; din = '1; addr = AW'(c);
        tick();
      end
    end
    idle();
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
  endtask

  initial begin
    reset_n = 1'b0; addr = '0;
    idle();
    tick();
    tick();
    chk("reset_dout",   32'(dout),   32'd0);
    chk("reset_ready",  32'(ready),  32'd0);
    chk("reset_addr_q", 32'(addr_q), 32'd0);

    reset_n = 1'b1;
    clear_seq();
    for (int a = 0; a < 32; a++) rd("clear_read", a);

    // Lane writes: second write only touches the low lane
    wr(3, 8'hA5, 2'b00);
    wr(3, 8'h3C, 2'b10);
    ce_n = 1'b0; strobe = 1'b1; we_n = '1; addr = AW'(3);
    push("lane_merge", 8'hAC);
    tick(); pop_chk(); idle();

    // Same-edge write and read, full word
    wr(5, 8'h01, 2'b00);
    ce_n = 1'b0; strobe = 1'b1; we_n = 2'b00; addr = AW'(5); din = 8'h10;
`ifdef WWR_BYPASS_EN
    push("wwr_full", 8'h10);
`else
    push("wwr_full", 8'h01);
`endif
    mwrite(5, 8'h10, 2'b00);
    tick(); pop_chk(); idle();
    rd("wwr_full_next", 5);
    chk("wwr_full_next_const", 32'(dout), 32'h10);

    // Same-edge write and read, low lane only
    wr(6, 8'h12, 2'b00);
    ce_n = 1'b0; strobe = 1'b1; we_n = 2'b10; addr = AW'(6); din = 8'h9A;
`ifdef WWR_BYPASS_EN
    push("wwr_lane", 8'h1A);
`else
    push("wwr_lane", 8'h12);
`endif
    mwrite(6, 8'h9A, 2'b10);
    tick(); pop_chk(); idle();
    rd("wwr_lane_next", 6);

    // Latched re-read of addr 7 while addr points elsewhere
    wr(9, 8'h99, 2'b00);
    rd("latch_7", 7);
    tick();
    wr(7, 8'h77, 2'b00);
    ce_n = 1'b1; strobe = 1'b1; we_n = '1; addr = AW'(9);
    push("reread_7", 8'h77);
    tick(); pop_chk(); idle();
    chk("reread_addr_q", 32'(addr_q), 32'd7);
    addr = AW'(2);
    tick();
    chk("hold_dout", 32'(dout), 32'h77);

    // Writes with ce_n high must be dropped
    ce_n = 1'b1; strobe = 1'b0; we_n = 2'b00; addr = AW'(7); din = 8'hEE;
    tick(); idle();
    rd("ce_gated_write", 7);

    // Out of range
    wr(25, 8'h33, 2'b00);
    rd("oor_25", 25);
    rd("oor_5", 5);
    rd("oor_alias_9", 9);
    rd("oor_alias_1", 1);
    rd("oor_read_clears", 30);
    rd("oor_7", 7);

    // Asynchronous reset mid-RUN
    reset_n = 1'b0;
    #1;
    chk("midreset_dout",   32'(dout),   32'd0);
    chk("midreset_ready",  32'(ready),  32'd0);
    chk("midreset_addr_q", 32'(addr_q), 32'd0);
    tick();
    reset_n = 1'b1;
    clear_seq();
    for (int a = 0; a < DEPTH; a++) rd("post_reset_read", a);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/part_wwr_ram.md
# part_wwr_ram

Parametrised synchronous write-while-read bipolar-RAM replacement. It generalises the 32x2 write-while-read part to arbitrary width and depth, with per-lane write enables, a registered address latch and output latch, and a post-reset clear sequencer. It is used wherever the processor models need small scratchpad, map or stack RAMs with deterministic contents after reset.

## Interface
Parameters:
- WIDTH, 2: data bits per word.
- DEPTH, 32: number of words; any value from 2 to 2**AW.
- AW, 5: address width.
- LANES, 2: number of write-enable lanes. WIDTH must be divisible by LANES. Lane k covers bits [k*WIDTH/LANES +: WIDTH/LANES].

Ports:
- clk, input, 1: sole clock. All state changes on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- ce_n, input, 1: chip enable, active low.
- addr, input, AW: word address.
- din, input, WIDTH: write data.
- we_n, input, LANES: per-lane write enables, active low. They are qualified by ce_n.
- strobe, input, 1: read strobe. It loads the output latch.
- dout, output, WIDTH: output latch.
- ready, output, 1: high once the clear sequence is complete.
- addr_q, output, AW: latched address, for debug and for the bench.

## Operation
- Reset, asynchronous:
  - dout=0, ready=0, addr_q=0.
  - FSM enters CLEAR; the clear counter is set to 0.
  - RAM contents are not reset directly.
- State CLEAR:
  - Each cycle writes all-zero to ram[counter], then increments the counter.
  - After writing word DEPTH-1, the FSM moves to RUN.
  - All of ce_n, we_n, strobe and addr are ignored. dout holds 0.
- State RUN:
  - Address latch: on each edge with ce_n=0, addr_q<=addr. Otherwise addr_q holds.
  - Write: on an edge with ce_n=0, each lane k with we_n[k]=0 writes din's lane k into ram[addr]. Other lanes are untouched.
  - Read, new address: on an edge with ce_n=0 and strobe=1, dout<=ram[addr].
  - Re-read: on an edge with ce_n=1 and strobe=1, dout<=ram[addr_q]. This returns any writes committed since the address was latched.
  - Hold: with strobe=0, dout holds.
- Out-of-range address (addr>=DEPTH):
  - Writes are dropped.
  - Reads return 0.
  - addr_q still latches the value.
- Reset asserted mid-RUN or mid-CLEAR: the FSM restarts CLEAR from word 0, and ready drops immediately.

## Timing
- Clear duration: exactly DEPTH cycles after reset_n deasserts. ready rises at the edge that performs the final clear write, so it is visible from cycle DEPTH.
- Read latency: 1 edge. dout is valid after the edge that samples strobe.
- Write latency: 1 edge. A read of the same address on the next edge sees the new data.
- Simultaneous read and write to the same address on one edge:
  - Lanes not written always return stored data.
  - Written lanes follow the Configuration rule below.
- No combinational path from any input to dout, ready or addr_q.

## Configuration
- Macro WWR_BYPASS_EN.
- Defined: a same-edge read and write to the same in-range address forwards din into dout for every lane with we_n[k]=0. This gives true write-while-read behaviour.
- Undefined: the read returns pre-write contents for all lanes (read-before-write), and the new data is visible from the next read.
- Re-read via addr_q (ce_n=1) involves no write on that edge, so it is unaffected by the macro.

## Test plan
- Reset and clear, DEPTH=32: release reset_n, then read all 32 addresses once ready=1.
  - ready=0 for cycles 0..31 and 1 from cycle 32.
  - Every read returns 0.
- Lane writes, WIDTH=8, LANES=2:
  - Write 8'hA5 to addr 3 with we_n=2'b00, then write 8'h3C with we_n=2'b10.
  - Read of addr 3 returns 8'hAC.
- Same-edge write and read: ram[5]=2'b01; on one edge ce_n=0, strobe=1, we_n=0, din=2'b10, addr=5.
  - dout=2'b10 with WWR_BYPASS_EN.
  - dout=2'b01 without it.
  - The next read returns 2'b10 in both builds.
- Latched re-read:
  - Latch addr 7 with ce_n=0, then drop ce_n.
  - Write addr 7 via a second ce_n=0 cycle with addr=7, then return ce_n=1 and pulse strobe.
  - dout shows the new value, and addr_q stays 7.
- Out of range, DEPTH=20, AW=5: write 2'b11 to addr 25, then read addr 25 and addr 5.
  - Both reads return 0.
- Reset mid-operation: assert reset_n=0 during RUN after writing nonzero data.
  - dout=0 and ready=0 immediately.
  - After DEPTH cycles all words read 0.
